// File: rtl/zjh_keypad_enc.sv
// zjh_keypad_enc: 4x4 matrix keypad scanner/encoder with debounce and a DA/KS handshake (74C922 style).
// Optional macro ZJH_KEYPAD_BCD_EN: keys whose code 4*row+col exceeds 9 are treated as no key.
module zjh_keypad_enc #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 16
) (
  input  logic       Clk,
  input  logic       MR,
  input  logic [3:0] X,
  output logic [3:0] Y,
  output logic [3:0] D,
  output logic       DA,
  output logic       KS
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  state_t        state_reg, state_next;
  logic [3:0]    x_meta_reg, xs_reg;
  logic [1:0]    row_reg, row_next;
  logic [DW-1:0] dwell_reg, dwell_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    col_reg, col_next;
  logic [3:0]    pat_reg, pat_next;
  logic [3:0]    d_reg, d_next;
  logic          da_reg, da_next;
  logic          ks_reg, ks_next;
  logic [3:0]    y_reg, y_next;

  logic [1:0]    low_col;
  logic          low_any;
  logic          key_ok;
  logic          all_high;
  logic          pat_match;
  logic [3:0]    key_code;
  logic [1:0]    row_inc;

  // Two-flop synchroniser on the column senses; idle level is all ones.
  always_ff @(posedge Clk or negedge MR) begin
    if (!MR) begin
      x_meta_reg <= 4'hF;
      xs_reg     <= 4'hF;
    end else begin
      x_meta_reg <= X;
      xs_reg     <= x_meta_reg;
    end
  end

  // Lowest-index low column wins when several keys share the driven row.
  always_comb begin
    low_col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!xs_reg[i]) begin
        low_col = 2'(i);
      end
    end
  end

  assign low_any   = ~&xs_reg;
  assign all_high  = &xs_reg;
  assign pat_match = (xs_reg == pat_reg);
  assign key_code  = {row_reg, low_col};
  assign row_inc   = row_reg + 2'd1;

`ifdef ZJH_KEYPAD_BCD_EN
  assign key_ok = low_any && (key_code <= 4'd9);
`else
  assign key_ok = low_any;
`endif

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    dwell_next = dwell_reg;
    cnt_next   = cnt_reg;
    col_next   = col_reg;
    pat_next   = pat_reg;
    d_next     = d_reg;
    da_next    = da_reg;
    ks_next    = 1'b0;

    case (state_reg)
      ST_SCAN: begin
        if (dwell_reg == DWELL_LAST) begin
          dwell_next = '0;
          if (key_ok) begin
            col_next = low_col;
            pat_next = xs_reg;
            if (DEBOUNCE == 1) begin
              d_next     = key_code;
              ks_next    = 1'b1;
              da_next    = 1'b1;
              cnt_next   = '0;
              state_next = ST_HELD;
            end else begin
              cnt_next   = CNT_ONE;
              state_next = ST_DEBOUNCE;
            end
          end else begin
            row_next = row_inc;
          end
        end else begin
          dwell_next = dwell_reg + DWELL_ONE;
        end
      end

      ST_DEBOUNCE: begin
        if (pat_match) begin
          if (cnt_reg == CNT_LAST) begin
            d_next     = {row_reg, col_reg};
            ks_next    = 1'b1;
            da_next    = 1'b1;
            cnt_next   = '0;
            state_next = ST_HELD;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end else begin
          // A bounce abandons this row; scanning picks up at the next one.
          row_next   = row_inc;
          dwell_next = '0;
          cnt_next   = '0;
          state_next = ST_SCAN;
        end
      end

      ST_HELD: begin
        if (all_high) begin
          if (DEBOUNCE == 1) begin
            da_next    = 1'b0;
            row_next   = row_inc;
            dwell_next = '0;
            cnt_next   = '0;
            state_next = ST_SCAN;
          end else begin
            cnt_next   = CNT_ONE;
            state_next = ST_RELEASE;
          end
        end
      end

      ST_RELEASE: begin
        if (all_high) begin
          if (cnt_reg == CNT_LAST) begin
            da_next    = 1'b0;
            row_next   = row_inc;
            dwell_next = '0;
            cnt_next   = '0;
            state_next = ST_SCAN;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end else begin
          cnt_next = '0;
        end
      end

      default: begin
        state_next = ST_SCAN;
        row_next   = 2'd0;
        dwell_next = '0;
        cnt_next   = '0;
      end
    endcase
  end

  // Row drive is registered from the next row index, so it freezes whenever the row does.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_row_drive
      assign y_next[gi] = (row_next != 2'(gi));
    end
  endgenerate

  always_ff @(posedge Clk or negedge MR) begin
    if (!MR) begin
      state_reg <= ST_SCAN;
      row_reg   <= 2'd0;
      dwell_reg <= '0;
      cnt_reg   <= '0;
      col_reg   <= 2'd0;
      pat_reg   <= 4'hF;
      d_reg     <= 4'd0;
      da_reg    <= 1'b0;
      ks_reg    <= 1'b0;
      y_reg     <= 4'b1110;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      dwell_reg <= dwell_next;
      cnt_reg   <= cnt_next;
      col_reg   <= col_next;
      pat_reg   <= pat_next;
      d_reg     <= d_next;
      da_reg    <= da_next;
      ks_reg    <= ks_next;
      y_reg     <= y_next;
    end
  end

  assign Y  = y_reg;
  assign D  = d_reg;
  assign DA = da_reg;
  assign KS = ks_reg;

endmodule

// File: doc/zjh_keypad_enc.md
# zjh_keypad_enc

- Synchronous 4x4 matrix-keypad encoder: it scans the key rows, debounces a press and outputs a 4-bit key code with a data-available handshake, in the manner of a 74C922.
- It is the input end of the BCD path. Its code feeds the counter preset inputs `A3..A0` and the comparator inputs `B3..B0`. The BCD-to-7-segment decoder is the output end of the same path.
- It runs in the same clock domain as the counter.

## Interface

**Parameters**
- `SCAN_DIV`, default 4: clocks each row is driven per scan step. Legal values are 3 and up, which covers the 2-FF synchroniser latency.
- `DEBOUNCE`, default 16: consecutive stable clocks needed to accept a press or a release. Legal range is 1..65535. The counter width is clog2(DEBOUNCE+1).

**Ports**
- `Clk` in 1: system clock. All logic is rising-edge.
- `MR` in 1: reset, asynchronous assert, active-low. It clears every flop.
- `X` in 4: column sense inputs, active-low with external pull-ups. They are double-flopped internally, giving `Xs`.
- `Y` out 4: row drive, one-hot active-low.
- `D` out 4: latched key code, equal to 4*row + col.
- `DA` out 1: data available. High from key acceptance until the release is debounced.
- `KS` out 1: one-clock strobe in the same cycle `DA` rises.

## Operation

**Reset values:** `Y`=1110, `D`=0000, `DA`=0, `KS`=0, state SCAN, row index 0, counters 0, synchroniser flops 1111.

**SCAN**
- Drive row r for SCAN_DIV clocks, then advance to r+1 mod 4, so that 3 wraps to 0.
- `Xs` is sampled only in the last dwell cycle of each row.
- If any bit of `Xs` is 0:
  - capture r;
  - capture col = the lowest-index low bit;
  - capture the pattern P = `Xs`;
  - freeze `Y`;
  - go to DEBOUNCE with count=1.
- If multiple keys are pressed in the same row, the lowest column wins. Keys in other rows are not seen until a later scan.

**DEBOUNCE**
- Each clock, `Xs`==P increments the count.
- Any mismatch returns to SCAN, restarting at row r+1 with a fresh dwell.
- When the count reaches DEBOUNCE:
  - latch `D` = 4r+col;
  - pulse `KS`=1 for one clock;
  - set `DA`=1;
  - go to HELD.

**HELD**
- `Y` stays frozen.
- Other presses are ignored.
- When `Xs`==1111, go to RELEASE with count=1.

**RELEASE**
- Each clock, `Xs`==1111 increments the count. Any low bit resets the count to 0 and the state stays in RELEASE.
- When the count reaches DEBOUNCE:
  - clear `DA`=0;
  - keep `D` unchanged;
  - go to SCAN at row r+1.

**General rules**
- `D` changes only in the `KS` cycle.
- `KS` never asserts while `DA` is already 1.

## Timing

- **Input latency:** 2 clocks from `X` to `Xs`.
- **Press to `KS`, worst case:** 4*SCAN_DIV + 2 + DEBOUNCE clocks from a clean, stable press.
- **Press to `KS`, best case:** 2 + DEBOUNCE clocks, when the key's row is in its dwell and the press lands so that it is sampled on the last dwell cycle.
- **Release to `DA` fall:** exactly 2 + DEBOUNCE clocks from a clean release.
- **`KS` width:** exactly 1 clock, coincident with the rising edge of `DA`.
- **Reset mid-operation:** `MR` low forces all outputs to their reset values immediately and asynchronously, in any state. After `MR` rises, a key still held is re-detected from SCAN row 0 and produces a new `KS`.
- **Outputs:** all outputs are registered, with no combinational path from `X` to any output.

## Configuration

- **Macro:** `ZJH_KEYPAD_BCD_EN`.
- **Defined:**
  - In SCAN, a press whose code 4r+col is greater than 9 is treated as no key, and scanning continues.
  - Such a key never produces `KS` or `DA`, and `D` is always 0..9.
  - Rows 2 and 3 still scan, because codes 8 and 9 are in row 2.
- **Undefined:** all 16 codes 0..15 are accepted.

## Test plan

All scenarios use SCAN_DIV=4 and DEBOUNCE=8.

1. **Reset:** `MR`=0 with `X` toggling → `Y`=1110, `D`=0, `DA`=0, `KS`=0. After `MR`=1, `Y` rotates 1110→1101→1011→0111→1110 every 4 clocks.
2. **Clean press:** X1 low while row 2 is driven, held for 100 clocks, then released → `D`=1001 (9), one `KS` pulse, `DA`=1. `DA`=0 exactly 10 clocks after release, and scanning resumes at row 3.
3. **Bounce:** row 1, X0 toggled every 3 clocks for 30 clocks, then held low → exactly one `KS`, `D`=4. Release with 5-clock bounces gives `DA` fall 10 clocks after the final high edge.
4. **Multi-key:** row 0, X0 and X3 low together → `D`=0. Pressing row 3 X2 while `DA`=1 → no new `KS`, and `D` stays 0.
5. **Reset mid-hold:** `MR` pulsed low while `DA`=1 with the key held at row 1 col 2 → immediate reset values. After `MR` rises, a new `KS` is seen with `D`=6.
6. **Macro:** row 3 X2 held (code 14).
   - With `ZJH_KEYPAD_BCD_EN` defined: no `KS`, `DA` stays 0, and `Y` keeps rotating.
   - Without it: `KS` pulses and `D`=1110.
